// File: rtl/mem_stage_module.sv
// mem_stage_module: ARM memory stage with wait-stated data RAM, freeze, MEM/WB register; MEM_BOUNDS_CHECK_EN enables access-fault checks
module mem_stage_module #(
  parameter int DATA_W      = 32,
  parameter int DEST_W      = 4,
  parameter int MEM_DEPTH   = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_r_m_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              freeze,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DEST_W-1:0] dest_out,
  output logic              mem_fault
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [DATA_W-1:0] BASE = DATA_W'(BASE_ADDR);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [DATA_W-1:0] ram [MEM_DEPTH];
  logic [DATA_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic req, bounds, fault, start, access;
  assign req    = mem_r_en_in | mem_w_en_in;
  assign off    = alu_res_in - BASE;
  assign idx    = off[IDX_W+1:2];
  assign bounds = (alu_res_in < BASE) | (|off[DATA_W-1:IDX_W+2]) | (|off[1:0]);
  assign fault  = CHECK & req & bounds;
  assign start  = req & !fault & (WS != 4'd0);
  assign freeze = !rst & ((state == BUSY) | ((state == IDLE) & start));
  assign access = !rst & !fault & ((state == DONE) | ((state == IDLE) & req & (WS == 4'd0)));
  always_ff @(posedge clk) begin
    if (access & mem_w_en_in) ram[idx] <= val_r_m_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
      mem_fault    <= 1'b0;
    end else begin
      state <= state == IDLE ? (start ? (WS == 4'd1 ? DONE : BUSY) : IDLE) :
               state == BUSY ? (cnt + 4'd1 == WS ? DONE : BUSY) : IDLE;
      cnt   <= state == IDLE ? (start ? 4'd1 : 4'd0) : state == BUSY ? cnt + 4'd1 : 4'd0;
      if (freeze) begin
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
        mem_fault    <= 1'b0;
      end else begin
        wb_en_out    <= wb_en_in & !fault;
        mem_r_en_out <= mem_r_en_in & !mem_w_en_in;
        alu_res_out  <= alu_res_in;
        dest_out     <= dest_in;
        mem_data_out <= (mem_r_en_in & !mem_w_en_in & !fault) ? ram[idx] : '0;
        mem_fault    <= fault;
      end
    end
  end
endmodule
